// File: rtl/tail_light_decoder.sv
// Receive-side checker for the 6-bit tail-light lamp bus: tracks the sender's
// sweeps, recovers the commanded mode and flags aborted or illegal sequences.
module tail_light_decoder #(
  parameter int OFF_CYCLES = 4,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       y,
  output logic [1:0]       mode,
  output logic             mode_valid,
  output logic             sweep_done,
  output logic             abort,
  output logic             err,
  output logic [CNT_W-1:0] sweep_count
);

  localparam int DW = 4;

  localparam logic [5:0] DARK = 6'b000000;

  localparam logic [1:0] M_OFF   = 2'b00;
  localparam logic [1:0] M_LEFT  = 2'b01;
  localparam logic [1:0] M_RIGHT = 2'b10;
  localparam logic [1:0] M_HAZ   = 2'b11;

  typedef enum logic [3:0] {
    IDLE, L1, L2, L3, R1, R2, R3, H1, H2, H3, ERR
  } state_t;

  state_t        state;
  logic [DW-1:0] dark;

  // Lamp pattern the sender shows while the decoder sits in a given state.
  function automatic logic [5:0] pat(input state_t s);
    case (s)
      L1:      pat = 6'b001000;
      L2:      pat = 6'b011000;
      L3:      pat = 6'b111000;
      R1:      pat = 6'b000100;
      R2:      pat = 6'b000110;
      R3:      pat = 6'b000111;
      H1:      pat = 6'b001100;
      H2:      pat = 6'b011110;
      H3:      pat = 6'b111111;
      default: pat = DARK;
    endcase
  endfunction

  function automatic state_t nxt(input state_t s);
    case (s)
      L1:      nxt = L2;
      L2:      nxt = L3;
      R1:      nxt = R2;
      R2:      nxt = R3;
      H1:      nxt = H2;
      H2:      nxt = H3;
      default: nxt = ERR;
    endcase
  endfunction

  function automatic logic is_last(input state_t s);
    is_last = (s == L3) || (s == R3) || (s == H3);
  endfunction

  function automatic logic [1:0] mode_of(input state_t s);
    case (s)
      L3:      mode_of = M_LEFT;
      R3:      mode_of = M_RIGHT;
      H3:      mode_of = M_HAZ;
      default: mode_of = M_OFF;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      dark        <= '0;
      mode        <= M_OFF;
      mode_valid  <= 1'b0;
      sweep_done  <= 1'b0;
      abort       <= 1'b0;
      err         <= 1'b0;
      sweep_count <= '0;
    end else begin
      sweep_done <= 1'b0;
      abort      <= 1'b0;
      err        <= 1'b0;
      case (state)
        IDLE: begin
          if (y == DARK) begin
            if (dark != DW'(OFF_CYCLES)) dark <= dark + 1'b1;
            if (dark == DW'(OFF_CYCLES - 1)) begin
              mode       <= M_OFF;
              mode_valid <= 1'b1;
            end
          end else begin
            dark <= '0;
            case (y)
              6'b001000: state <= L1;
              6'b000100: state <= R1;
              6'b001100: state <= H1;
              default: begin
                state <= ERR;
                err   <= 1'b1;
              end
            endcase
          end
        end
        ERR: begin
          // err already pulsed on entry; just wait for the bus to go dark
          if (y == DARK) begin
            state <= IDLE;
            dark  <= DW'(1);
          end
        end
        default: begin
          if (y == pat(state)) begin
            state <= state;
          end else if (y == DARK) begin
            // the dark sample that lands us in IDLE is the first dark count
            state <= IDLE;
            dark  <= DW'(1);
            if (is_last(state)) begin
              sweep_done <= 1'b1;
              mode       <= mode_of(state);
              mode_valid <= 1'b1;
              if (sweep_count != '1) sweep_count <= sweep_count + 1'b1;
            end else begin
              abort <= 1'b1;
            end
          end else if (!is_last(state) && y == pat(nxt(state))) begin
            state <= nxt(state);
          end else begin
            state <= ERR;
            err   <= 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: doc/tail_light_decoder.md
# tail_light_decoder

Sampling decoder for the 6-bit tail-light lamp bus driven by the turn-signal FSM. It runs on the same clock as the FSM and recovers the commanded mode (off, left, right or hazard) from the lamp sweeps. It also counts completed sweeps and flags illegal lamp sequences and sweeps that are cut short. It sits on the receive side of the lamp bus as a checker and status source.

## Interface
- OFF_CYCLES, 4: number of consecutive all-dark samples in IDLE that declare mode OFF (range 2..15).
- CNT_W, 8: width of the sweep counter.
- clk  input  1  system clock; all logic updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- y  input  6  lamp bus {LC,LB,LA,RA,RB,RC}, bit 5 = LC.
- mode  output  2  decoded mode: 00 off, 01 left, 10 right, 11 hazard.
- mode_valid  output  1  high once a mode has been established.
- sweep_done  output  1  one-cycle pulse when a sweep completes.
- abort  output  1  one-cycle pulse when a sweep is cut short by all-dark.
- err  output  1  one-cycle pulse when an illegal pattern is sampled.
- sweep_count  output  CNT_W  number of completed sweeps; saturates at all-ones.

## Operation
- Legal sweeps, each step from the previous:
  - Left: 001000 -> 011000 -> 111000 -> 000000.
  - Right: 000100 -> 000110 -> 000111 -> 000000.
  - Hazard: 001100 -> 011110 -> 111111 -> 000000.
- Sweep FSM states: IDLE, L1, L2, L3, R1, R2, R3, H1, H2, H3, ERR.
- In any state, sampling the same pattern as that state's pattern holds the state. This tolerates a slower sender.
- IDLE:
  - 000000 holds IDLE and increments the dark counter.
  - 001000 goes to L1, 000100 goes to R1, 001100 goes to H1.
  - Any other pattern goes to ERR.
  - Any exit from IDLE clears the dark counter.
- L1->L2->L3, R1->R2->R3 and H1->H2->H3 advance on the next legal pattern of their own sweep.
- Sweep completion: sampling 000000 in L3, R3 or H3:
  - goes to IDLE;
  - pulses sweep_done;
  - sets mode to 01, 10 or 11 respectively and sets mode_valid;
  - increments sweep_count.
- Cut-short sweep: sampling 000000 in L1/L2, R1/R2 or H1/H2 (sender reset mid-sweep):
  - goes to IDLE and pulses abort;
  - mode and sweep_count are unchanged.
- Illegal pattern: any other pattern in an L, R or H state goes to ERR and pulses err. This includes a mode switch without passing through 000000, and skipped or reversed steps.
- ERR:
  - err is pulsed only on entry.
  - Stays in ERR until 000000 is sampled, then returns to IDLE with no abort pulse.
  - mode and mode_valid are unchanged.
- Dark counter:
  - Counts consecutive 000000 samples while in IDLE and saturates at OFF_CYCLES.
  - The sample that completes a sweep (entry into IDLE) counts as 1.
  - When the count reaches OFF_CYCLES: mode becomes 00 and mode_valid is set.
- sweep_count is CNT_W bits, unsigned, and holds at 2^CNT_W-1 once reached.

## Timing
- Reset values, all in the cycle after reset is sampled high:
  - FSM state: IDLE.
  - mode: 00.
  - mode_valid: 0.
  - sweep_done, abort, err: 0.
  - sweep_count: 0.
  - dark counter: 0.
- Reset sampled high overrides y in the same edge, including mid-sweep and in ERR. No pulse is generated on reset.
- All outputs are registered and driven directly from flops.
- Latency is one clock: the pattern sampled at edge n is reflected in the outputs after edge n.
- Pulses are exactly one cycle wide. Back-to-back sweeps, 4 samples apart, give sweep_done every 4th cycle.
- sweep_done and abort are mutually exclusive; so are err and sweep_done.
- mode changes only on a sweep_done edge or on an OFF_CYCLES timeout edge.
- y is assumed to be synchronous to clk. No synchronizer is included.

## Test plan
- Left steady: after reset, y repeats 001000,011000,111000,000000 for 3 sweeps.
  - sweep_done pulses on samples 4, 8 and 12.
  - mode becomes 01 with mode_valid=1 after sample 4.
  - sweep_count ends at 3; err=0 and abort=0 throughout.
- Hazard then right: 2 hazard sweeps, then 2 right sweeps, with the sender advancing directly.
  - mode goes 11, then 10 on the first right completion.
  - sweep_count ends at 4; no err.
- Off timeout (OFF_CYCLES=4): one left sweep, then y held at 000000.
  - mode goes 01, then 00 after the 3rd extra dark sample, since the completion sample counts as 1.
  - mode_valid stays 1.
- Illegal and abort:
  - y = 001000, 011000, 000110: err pulses once; 000110 held for 3 cycles gives no further err; then 000000 returns to IDLE.
  - y = 000100, 000000: abort pulses and sweep_count is unchanged.
- Reset mid-operation: reset=1 for one cycle while in H2 with sweep_count=5 and mode=11.
  - Next cycle: mode=00, mode_valid=0, sweep_count=0, no pulses.
  - Then 001000 is accepted as L1.
- Saturation (CNT_W=2): 5 left sweeps.
  - sweep_count reads 1, 2, 3, 3, 3.
  - sweep_done still pulses 5 times.
